// File: rtl/param_register_file.sv
// param_register_file
// Multi-port integer register file for the GATE datapath, placed between the
// decode and execute stages. It has three registered read ports and two write
// ports. Port 0 carries ALU writeback. Port 1 carries late load returns. A
// per-register busy scoreboard tracks registers that are still waiting for a
// load to come back. The BYPASS parameter chooses write-first or read-first
// behaviour when a read and a write hit the same register at the same edge.
module param_register_file #(
    parameter int                 DATA_W  = 16,
    parameter int                 ADDR_W  = 4,
    parameter int                 SP_IDX  = 2,
    parameter logic [DATA_W-1:0]  SP_INIT = 16'hFFFF,
    parameter bit                 BYPASS  = 1'b1
) (
    input  logic                     CLK,
    input  logic                     reset,
    input  logic                     regWrite0,
    input  logic [ADDR_W-1:0]        rd0,
    input  logic signed [DATA_W-1:0] dataWrite0,
    input  logic                     regWrite1,
    input  logic [ADDR_W-1:0]        rd1,
    input  logic signed [DATA_W-1:0] dataWrite1,
    input  logic                     markBusy,
    input  logic [ADDR_W-1:0]        mbRd,
    input  logic [ADDR_W-1:0]        rs0,
    input  logic [ADDR_W-1:0]        rs1,
    input  logic [ADDR_W-1:0]        rs2,
    output logic signed [DATA_W-1:0] A,
    output logic signed [DATA_W-1:0] B,
    output logic signed [DATA_W-1:0] C,
    output logic                     busyA,
    output logic                     busyB
);

    localparam int NREGS = 2 ** ADDR_W;

    logic [DATA_W-1:0] regs_q [NREGS];
    logic [DATA_W-1:0] regs_d [NREGS];
    logic [NREGS-1:0]  busy_q;
    logic [NREGS-1:0]  busy_d;

    logic [DATA_W-1:0] a_q, b_q, c_q;
    logic [DATA_W-1:0] a_d, b_d, c_d;
    logic              busyA_q, busyB_q;
    logic              busyA_d, busyB_d;

    // Post-edge register contents. Port 1 is applied after port 0 so it wins
    // when both ports target the same address. Register 0 stays zero.
    always_comb begin
        regs_d = regs_q;
        if (regWrite0) begin
            regs_d[rd0] = dataWrite0;
        end
        if (regWrite1) begin
            regs_d[rd1] = dataWrite1;
        end
        regs_d[0] = '0;
    end

    // Post-edge busy scoreboard. A load return clears its register. A new
    // markBusy is applied afterwards so a fresh pending load wins a same-edge
    // clear. Register 0 can never be busy.
    always_comb begin
        busy_d = busy_q;
        if (regWrite1) begin
            busy_d[rd1] = 1'b0;
        end
        if (markBusy) begin
            busy_d[mbRd] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    // Read-port selection. Write-first reads the post-edge state; read-first
    // reads the state as it was before this edge.
    always_comb begin
        if (BYPASS) begin
            a_d     = regs_d[rs0];
            b_d     = regs_d[rs1];
            c_d     = regs_d[rs2];
            busyA_d = busy_d[rs0];
            busyB_d = busy_d[rs1];
        end else begin
            a_d     = regs_q[rs0];
            b_d     = regs_q[rs1];
            c_d     = regs_q[rs2];
            busyA_d = busy_q[rs0];
            busyB_d = busy_q[rs1];
        end
    end

    // State update. Reset discards any write or markBusy arriving in the same
    // cycle and reloads the stack pointer with its initial value.
    always_ff @(posedge CLK) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= (i == SP_IDX && i != 0) ? SP_INIT : '0;
            end
            busy_q  <= '0;
            a_q     <= '0;
            b_q     <= '0;
            c_q     <= '0;
            busyA_q <= 1'b0;
            busyB_q <= 1'b0;
        end else begin
            regs_q  <= regs_d;
            busy_q  <= busy_d;
            a_q     <= a_d;
            b_q     <= b_d;
            c_q     <= c_d;
            busyA_q <= busyA_d;
            busyB_q <= busyB_d;
        end
    end

    assign A     = a_q;
    assign B     = b_q;
    assign C     = c_q;
    assign busyA = busyA_q;
    assign busyB = busyB_q;

endmodule
